// File: rtl/sign_max_pkg.sv
// -----------------------------------------------------------------------------
// sign_max_pkg
// Shared definitions for the signed frame-maximum tracker.
//   DATA_W : sample width (two's-complement signed)
//   CNT_W  : sample-count / index width
//   stateT : tracker FSM states (IDLE accepts, CMP resolves a compare, DONE
//            publishes the frame result)
// -----------------------------------------------------------------------------
package sign_max_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/sign_max_track.sv
// -----------------------------------------------------------------------------
// sign_max_track
// Tracks the signed maximum of each frame of FRAME_LEN samples. The magnitude
// decision is made by an external signed comparator: the block presents the
// candidate on CMP_A and the running maximum on CMP_B, and uses only CMP_AGEB.
// Ties (CMP_AGEB=1 on equality) select the later sample.
//
// Parameters
//   FRAME_LEN  samples per frame, 1..255
// Ports
//   CLK        clock, rising edge
//   RESET_N    asynchronous active-low reset
//   DIN        signed input sample
//   DIN_VALID  DIN holds a sample
//   DIN_READY  sample accepted this cycle when DIN_VALID is also high
//   CMP_A      registered candidate sample to the comparator (DataA)
//   CMP_B      running maximum to the comparator (DataB)
//   CMP_AGEB   comparator result, CMP_A >= CMP_B (signed)
//   MAX_OUT    maximum of the last completed frame, held until the next one
//   MAX_IDX    0-based position of MAX_OUT in its frame (SIGN_MAX_IDX_EN only)
//   MAX_VALID  one-cycle pulse marking a new MAX_OUT
//
// Configuration macro: SIGN_MAX_IDX_EN adds MAX_IDX and the index tracking.
// -----------------------------------------------------------------------------
module sign_max_track
  import sign_max_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [DATA_W-1:0] CMP_A,
  output logic [DATA_W-1:0] CMP_B,
  input  logic              CMP_AGEB,
  output logic [DATA_W-1:0] MAX_OUT,
`ifdef SIGN_MAX_IDX_EN
  output logic [CNT_W-1:0]  MAX_IDX,
`endif
  output logic              MAX_VALID
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  stateT                     state;
  logic        [CNT_W-1:0]   count;
  logic signed [DATA_W-1:0]  runMax;
  logic signed [DATA_W-1:0]  cmpA;
  logic signed [DATA_W-1:0]  maxOut;
  logic                      maxValid;
  logic        [CNT_W-1:0]   countInc;
  logic signed [DATA_W-1:0]  nextMax;

`ifdef SIGN_MAX_IDX_EN
  logic        [CNT_W-1:0]   runIdx;
  logic        [CNT_W-1:0]   maxIdx;
  logic        [CNT_W-1:0]   nextIdx;
`endif

  assign countInc = count + 1'b1;

  // Running maximum after the pending compare resolves; used both to update
  // the running state and to publish the result in the same edge.
  assign nextMax  = CMP_AGEB ? cmpA : runMax;
`ifdef SIGN_MAX_IDX_EN
  assign nextIdx  = CMP_AGEB ? count : runIdx;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      count    <= '0;
      runMax   <= '0;
      cmpA     <= '0;
      maxOut   <= '0;
      maxValid <= 1'b0;
`ifdef SIGN_MAX_IDX_EN
      runIdx   <= '0;
      maxIdx   <= '0;
`endif
    end else begin
      maxValid <= 1'b0;
      case (state)
        IDLE: begin
          if (DIN_VALID) begin
            if (count == '0) begin
              // First sample seeds the running maximum, no compare needed.
              runMax <= DIN;
              cmpA   <= DIN;
              count  <= countInc;
`ifdef SIGN_MAX_IDX_EN
              runIdx <= '0;
`endif
              if (FRAME_LEN == 1) begin
                // Result is published on entry to DONE so MAX_OUT is already
                // valid during the MAX_VALID cycle.
                state    <= DONE;
                maxOut   <= DIN;
                maxValid <= 1'b1;
`ifdef SIGN_MAX_IDX_EN
                maxIdx   <= '0;
`endif
              end
            end else begin
              cmpA  <= DIN;
              state <= CMP;
            end
          end
        end

        CMP: begin
          // count still holds the candidate's 0-based position here.
          runMax <= nextMax;
          count  <= countInc;
`ifdef SIGN_MAX_IDX_EN
          runIdx <= nextIdx;
`endif
          if (countInc == FRAME_CNT) begin
            state    <= DONE;
            maxOut   <= nextMax;
            maxValid <= 1'b1;
`ifdef SIGN_MAX_IDX_EN
            maxIdx   <= nextIdx;
`endif
          end else begin
            state <= IDLE;
          end
        end

        DONE: begin
          count <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign DIN_READY = (state == IDLE);
  assign CMP_A     = cmpA;
  assign CMP_B     = runMax;
  assign MAX_OUT   = maxOut;
  assign MAX_VALID = maxValid;
`ifdef SIGN_MAX_IDX_EN
  assign MAX_IDX   = maxIdx;
`endif

endmodule

// File: tb/tb_sign_max_track.sv
// -----------------------------------------------------------------------------
// tb_sign_max_track
// Three instances (FRAME_LEN 4, 3, 1) share the clock, reset and DIN; only the
// selected instance sees DIN_VALID. The external comparator is modelled with a
// signed >= per instance. The reference model collects accepted samples per
// frame, takes the signed maximum (latest position on ties) and predicts the
// ready pattern and the MAX_VALID cycle from the handshake rules.
// -----------------------------------------------------------------------------
module tb_sign_max_track;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] din;
  logic [2:0] dinValid;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int LEN = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    logic       ready, maxValid, ageb;
    logic [7:0] cmpA, cmpB, maxOut, maxIdx;

    assign ageb = ($signed(cmpA) >= $signed(cmpB));

    sign_max_track #(.FRAME_LEN(LEN)) dut (
      .CLK       (clk),
      .RESET_N   (rstN),
      .DIN       (din),
      .DIN_VALID (dinValid[g]),
      .DIN_READY (ready),
      .CMP_A     (cmpA),
      .CMP_B     (cmpB),
      .CMP_AGEB  (ageb),
      .MAX_OUT   (maxOut),
`ifdef SIGN_MAX_IDX_EN
      .MAX_IDX   (maxIdx),
`endif
      .MAX_VALID (maxValid)
    );
`ifndef SIGN_MAX_IDX_EN
    assign maxIdx = '0;
`endif
  end

  int         sel;
  int         curLen;
  logic       obsReady, obsMaxValid;
  logic [7:0] obsMaxOut, obsMaxIdx, obsCmpA, obsCmpB;

  always_comb begin
    obsReady    = gd[0].ready;
    obsMaxValid = gd[0].maxValid;
    obsMaxOut   = gd[0].maxOut;
    obsMaxIdx   = gd[0].maxIdx;
    obsCmpA     = gd[0].cmpA;
    obsCmpB     = gd[0].cmpB;
    case (sel)
      1: begin
        obsReady    = gd[1].ready;
        obsMaxValid = gd[1].maxValid;
        obsMaxOut   = gd[1].maxOut;
        obsMaxIdx   = gd[1].maxIdx;
        obsCmpA     = gd[1].cmpA;
        obsCmpB     = gd[1].cmpB;
      end
      2: begin
        obsReady    = gd[2].ready;
        obsMaxValid = gd[2].maxValid;
        obsMaxOut   = gd[2].maxOut;
        obsMaxIdx   = gd[2].maxIdx;
        obsCmpA     = gd[2].cmpA;
        obsCmpB     = gd[2].cmpB;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic signed [7:0] frameQ[$];
  int                busyLeft;
  int                pulseAt;
  int                n = 0;
  logic [7:0]        heldMax, heldIdx, pendMax, pendIdx;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    frameQ.delete();
    busyLeft = 0;
    pulseAt  = -1;
    heldMax  = 8'h00;
    heldIdx  = 8'h00;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then let
  // the model decide whether this cycle's sample is taken.
  task automatic cycle(input bit v, input logic [7:0] d, output bit acc);
    logic signed [7:0] m;
    int                mi, pos;
    bit                expValid;
    @(negedge clk);
    din      = d;
    dinValid = v ? 3'(3'b001 << sel) : 3'b000;
    n++;
    expValid = (n == pulseAt);
    if (expValid) begin
      heldMax = pendMax;
      heldIdx = pendIdx;
    end
    chk("din_ready", {7'b0, obsReady}, {7'b0, busyLeft == 0});
    chk("max_valid", {7'b0, obsMaxValid}, {7'b0, expValid});
    chk("max_out", obsMaxOut, heldMax);
`ifdef SIGN_MAX_IDX_EN
    chk("max_idx", obsMaxIdx, heldIdx);
`endif
    acc = v && (busyLeft == 0);
    if (acc) begin
      pos = frameQ.size();
      frameQ.push_back(d);
      if (frameQ.size() == curLen) begin
        m  = frameQ[0];
        mi = 0;
        for (int i = 1; i < frameQ.size(); i++)
          if (frameQ[i] >= m) begin
            m  = frameQ[i];
            mi = i;
          end
        pendMax  = m;
        pendIdx  = 8'(mi);
        pulseAt  = n + ((curLen == 1) ? 1 : 2);
        busyLeft = (curLen == 1) ? 1 : 2;
        frameQ.delete();
      end else begin
        busyLeft = (pos == 0) ? 0 : 1;
      end
    end else if (busyLeft > 0) begin
      busyLeft--;
    end
  endtask

  task automatic sendSample(input logic [7:0] d);
    bit acc;
    int tries = 0;
    do begin
      cycle(1'b1, d, acc);
      tries++;
    end while (!acc && tries < 8);
    if (!acc) chk("send_timeout", 8'h00, 8'h01);
  endtask

  task automatic idle(input int cnt);
    bit acc;
    for (int i = 0; i < cnt; i++) cycle(1'b0, 8'($urandom), acc);
  endtask

  task automatic randomRun(input int cnt);
    bit acc;
    for (int i = 0; i < cnt; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom), acc);
  endtask

  // Asserts reset between edges so the clear is seen without a clock edge.
  task automatic doReset();
    @(negedge clk);
    rstN     = 1'b0;
    dinValid = 3'b000;
    #1;
    chk("rst_ready", {7'b0, obsReady}, 8'h01);
    chk("rst_valid", {7'b0, obsMaxValid}, 8'h00);
    chk("rst_max_out", obsMaxOut, 8'h00);
    chk("rst_cmp_a", obsCmpA, 8'h00);
    chk("rst_cmp_b", obsCmpB, 8'h00);
`ifdef SIGN_MAX_IDX_EN
    chk("rst_max_idx", obsMaxIdx, 8'h00);
`endif
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    rstN     = 1'b0;
    din      = 8'h00;
    dinValid = 3'b000;
    sel      = 0;
    curLen   = 4;
    modelReset();

    // FRAME_LEN = 4
    doReset();
    sendSample(8'd5); sendSample(8'hFD); sendSample(8'd7); sendSample(8'd2);
    idle(4);
    sendSample(8'h80); sendSample(8'hFF); sendSample(8'h80); sendSample(8'hFE);
    idle(4);
    for (int i = 0; i < 12; i++) sendSample(8'($urandom));
    idle(4);
    randomRun(60);
    idle(4);
    // Reset in the middle of a frame discards it.
    doReset();
    sendSample(8'd10); sendSample(8'd20);
    doReset();
    idle(4);
    sendSample(8'd1); sendSample(8'd2); sendSample(8'd3); sendSample(8'd9);
    idle(4);
    doReset();

    // FRAME_LEN = 3
    sel    = 1;
    curLen = 3;
    doReset();
    sendSample(8'd4); sendSample(8'd4); sendSample(8'd4);
    idle(4);
    randomRun(40);
    idle(4);

    // FRAME_LEN = 1
    sel    = 2;
    curLen = 1;
    doReset();
    sendSample(8'h80);
    idle(3);
    randomRun(30);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_max_track.md
SIGN_MAX_TRACK -- requirements
Module: sign_max_track

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning the number of samples per frame (legal range 1..255).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port DIN  input  8  two's-complement signed sample.
REQ-005 SHALL have port DIN_VALID  input  1  DIN holds a sample.
REQ-006 SHALL have port DIN_READY  output  1  block accepts DIN this cycle.
REQ-007 SHALL have port CMP_A  output  8  registered candidate sample, driven to the signed comparator's DataA.
REQ-008 SHALL have port CMP_B  output  8  current running maximum, driven to the signed comparator's DataB.
REQ-009 SHALL have port CMP_AGEB  input  1  comparator result, 1 when CMP_A >= CMP_B (signed).
REQ-010 SHALL have port MAX_OUT  output  8  signed maximum of the last completed frame.
REQ-011 SHALL have port MAX_IDX  output  8  0-based position of MAX_OUT within its frame (present only under the configuration macro).
REQ-012 SHALL have port MAX_VALID  output  1  one-cycle pulse marking a new MAX_OUT.

Function
REQ-013 SHALL implement FSM states IDLE, CMP and DONE.
REQ-014 In IDLE, DIN_READY SHALL be 1; in CMP and DONE, DIN_READY SHALL be 0.
REQ-015 A sample SHALL be accepted only on a cycle where DIN_VALID and DIN_READY are both 1.
REQ-016 First sample of a frame (count 0): SHALL load both the running maximum and CMP_A with DIN and set the index to 0, with no comparison; then next state SHALL be DONE if FRAME_LEN=1, else IDLE.
REQ-017 Later samples: SHALL register DIN into CMP_A and go to CMP; CMP_B SHALL present the running maximum throughout.
REQ-018 In CMP, if CMP_AGEB=1 the running maximum SHALL take CMP_A and the index SHALL take the sample position, so ties select the later sample; if CMP_AGEB=0 both SHALL hold. Count SHALL increment.
REQ-019 From CMP, next state SHALL be DONE if the updated count equals FRAME_LEN, else IDLE.
REQ-020 In DONE, MAX_OUT and MAX_IDX SHALL be loaded from the running state and MAX_VALID SHALL be 1 for exactly this one cycle.
REQ-021 In DONE, the count SHALL clear to 0 and next state SHALL be IDLE.
REQ-022 MAX_OUT and MAX_IDX SHALL hold their values until the next DONE.
REQ-023 Throughput SHALL be one sample per 2 cycles; latency from the last accepted sample to MAX_VALID SHALL be 2 cycles.
REQ-024 Comparison SHALL be signed 8-bit only, taken solely from CMP_AGEB, with no internal magnitude compare.
REQ-025 Sample count SHALL be 8 bits and SHALL never wrap within a frame.

Reset
REQ-026 When RESET_N=0, asynchronously: state SHALL be IDLE; count, running maximum, index, CMP_A, MAX_OUT and MAX_IDX SHALL be 0x00; MAX_VALID SHALL be 0.
REQ-027 Reset mid-frame SHALL discard the partial frame without a MAX_VALID pulse; the first accepted sample after release SHALL be sample 0.

Configuration
REQ-028 Macro SIGN_MAX_IDX_EN defined: MAX_IDX port and index tracking SHALL be present.
REQ-029 Macro SIGN_MAX_IDX_EN absent: MAX_IDX port and index logic SHALL be removed, with all other behaviour identical.

Structure
REQ-030 Shared package sign_max_pkg SHALL hold the state enum (IDLE/CMP/DONE), DATA_W=8 and CNT_W=8.
REQ-031 The block SHALL be a single module; the signed comparator SHALL remain external, connected via CMP_A/CMP_B/CMP_AGEB.

Verification
REQ-032 FRAME_LEN=4, samples 5,-3,7,2 -> MAX_VALID pulse 2 cycles after the last sample; MAX_OUT=0x07, MAX_IDX=2.
REQ-033 FRAME_LEN=4, samples -128,-1,-128,-2 -> MAX_OUT=0xFF, MAX_IDX=1 (confirms signed ordering).
REQ-034 FRAME_LEN=3, samples 4,4,4 -> MAX_OUT=0x04, MAX_IDX=2 (tie takes later sample).
REQ-035 FRAME_LEN=1, sample 0x80 -> MAX_VALID 1 cycle after acceptance; MAX_OUT=0x80, MAX_IDX=0.
REQ-036 DIN_VALID held at 1 continuously -> DIN_READY alternates 1/0; no sample lost or duplicated across 3 frames.
REQ-037 RESET_N pulsed low after 2 of 4 samples -> no MAX_VALID and outputs 0x00; the next 4 samples 1,2,3,9 -> MAX_OUT=0x09, MAX_IDX=3.
